// File: rtl/counter_sched_pkg.sv
// Shared types and constants for the counter_sched burst scheduler.
package counter_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam logic CH0 = 1'b0;
  localparam logic CH1 = 1'b1;

  localparam int DIV_LOG2_DEF = 2;

endpackage

// File: rtl/counter_sched_rr.sv
// Two-way round-robin pick; the last-grant pointer advances only when a pick is taken.
module counter_sched_rr
  import counter_sched_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic req0,
  input  logic req1,
  input  logic take,
  output logic valid,
  output logic pick
);

  logic last_q, last_d;

  always_comb begin
    valid = req0 | req1;
    if (req0 && req1) pick = ~last_q;
    else if (req1)    pick = CH1;
    else              pick = CH0;
    last_d = take ? pick : last_q;
  end

  // Pointer starts at CH1 so requester 0 wins the first tie.
  always_ff @(posedge clk) begin
    if (rst) last_q <= CH1;
    else     last_q <= last_d;
  end

endmodule

// File: rtl/counter_sched.sv
// Round-robin scheduler issuing enable bursts to a shared dual-channel event counter.
// state | meaning
// IDLE  | waiting; Clr beats requests, otherwise round-robin grant
// CLEAR | one-cycle Cnt_Reset pulse
// RUN   | Cnt_En high while the remaining count is nonzero
// DONE  | one-cycle Done pulse for the granted requester
module counter_sched
  import counter_sched_pkg::*;
#(
  parameter int LEN_W    = 8,
  parameter int DIV_LOG2 = DIV_LOG2_DEF
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Req0,
  input  logic [LEN_W-1:0] Len0,
  input  logic             Req1,
  input  logic [LEN_W-1:0] Len1,
  input  logic             Clr,
  output logic             Ack0,
  output logic             Ack1,
  output logic             Done0,
  output logic             Done1,
  output logic             Busy,
  output logic             Cnt_En,
  output logic             Cnt_Slt,
  output logic             Cnt_Reset
);

  localparam int CW = LEN_W + DIV_LOG2;

  state_e          state_q, state_d;
  logic [CW-1:0]   rem_q, rem_d;
  logic            ch_q, ch_d;
  logic            ack0_q, ack0_d, ack1_q, ack1_d;
  logic            done0_q, done0_d, done1_q, done1_d;
  logic            busy_q, busy_d, en_q, en_d, slt_q, slt_d, crst_q, crst_d;
  logic            rr_valid, rr_pick, rr_take;
  logic [CW-1:0]   load_len;

  counter_sched_rr u_rr (
    .clk   (Clk),
    .rst   (Reset),
    .req0  (Req0),
    .req1  (Req1),
    .take  (rr_take),
    .valid (rr_valid),
    .pick  (rr_pick)
  );

  // Channel 1 counts prescaled events, so its burst is scaled to whole prescaler periods.
  assign load_len = (rr_pick == CH1) ? (CW'(Len1) << DIV_LOG2) : CW'(Len0);

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    ch_d    = ch_q;
    ack0_d  = 1'b0;
    ack1_d  = 1'b0;
    done0_d = 1'b0;
    done1_d = 1'b0;
    en_d    = 1'b0;
    slt_d   = 1'b0;
    crst_d  = 1'b0;
    rr_take = 1'b0;
    case (state_q)
      IDLE: begin
        if (Clr) begin
          state_d = CLEAR;
          crst_d  = 1'b1;
        end else if (rr_valid) begin
          rr_take = 1'b1;
          state_d = RUN;
          ch_d    = rr_pick;
          rem_d   = load_len;
          ack0_d  = (rr_pick == CH0);
          ack1_d  = (rr_pick == CH1);
          en_d    = (load_len != '0);
          slt_d   = rr_pick;
        end
      end
      CLEAR: state_d = IDLE;
      RUN: begin
        slt_d = ch_q;
        rem_d = (rem_q != '0) ? rem_q - CW'(1) : '0;
        // Terminal count: the current cycle is the last En cycle (or a zero-length burst).
        if (rem_q <= CW'(1)) begin
          state_d = DONE;
          done0_d = (ch_q == CH0);
          done1_d = (ch_q == CH1);
        end else begin
          en_d = 1'b1;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      rem_q   <= '0;
      ch_q    <= CH0;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
      busy_q  <= 1'b0;
      en_q    <= 1'b0;
      slt_q   <= 1'b0;
      crst_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      ch_q    <= ch_d;
      ack0_q  <= ack0_d;
      ack1_q  <= ack1_d;
      done0_q <= done0_d;
      done1_q <= done1_d;
      busy_q  <= busy_d;
      en_q    <= en_d;
      slt_q   <= slt_d;
      crst_q  <= crst_d;
    end
  end

  assign Ack0      = ack0_q;
  assign Ack1      = ack1_q;
  assign Done0     = done0_q;
  assign Done1     = done1_q;
  assign Busy      = busy_q;
  assign Cnt_En    = en_q;
  assign Cnt_Slt   = slt_q;
  assign Cnt_Reset = crst_q;

endmodule

// File: tb/tb_counter_sched.sv
// Directed bench for counter_sched with a behavioural model of the shared event counter.
module tb_counter_sched;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       Req0 = 1'b0, Req1 = 1'b0, Clr = 1'b0;
  logic [7:0] Len0 = 8'd0, Len1 = 8'd0;
  logic       Ack0, Ack1, Done0, Done1, Busy, Cnt_En, Cnt_Slt, Cnt_Reset;

  int checks = 0;
  int errors = 0;

  logic [63:0] out0 = 64'd0, out1 = 64'd0;
  logic [1:0]  pre = 2'd0;
  logic        overlap = 1'b0;
  logic [7:0]  ob;

  counter_sched #(.LEN_W(8), .DIV_LOG2(2)) dut (
    .Clk(Clk), .Reset(Reset), .Req0(Req0), .Len0(Len0), .Req1(Req1), .Len1(Len1),
    .Clr(Clr), .Ack0(Ack0), .Ack1(Ack1), .Done0(Done0), .Done1(Done1), .Busy(Busy),
    .Cnt_En(Cnt_En), .Cnt_Slt(Cnt_Slt), .Cnt_Reset(Cnt_Reset)
  );

  always #5 Clk = ~Clk;

  // Bit order: Ack0 Ack1 Done0 Done1 Busy Cnt_En Cnt_Slt Cnt_Reset
  assign ob = {Ack0, Ack1, Done0, Done1, Busy, Cnt_En, Cnt_Slt, Cnt_Reset};

  // Shared counter: channel 1 increments once per 4 enabled cycles.
  always @(posedge Clk) begin
    if (Reset || Cnt_Reset) begin
      out0 <= 64'd0;
      out1 <= 64'd0;
      pre  <= 2'd0;
    end else if (Cnt_En) begin
      if (!Cnt_Slt) out0 <= out0 + 64'd1;
      else begin
        pre <= pre + 2'd1;
        if (pre == 2'd3) out1 <= out1 + 64'd1;
      end
    end
  end

  always @(negedge Clk) if (Cnt_Reset && Cnt_En) overlap = 1'b1;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Entered on the Ack cycle; returns on the Done cycle with the En cycles counted.
  task automatic wait_done(input string tag, input logic ch, output int ens);
    int n = 0;
    int slt_bad = 0;
    ens = 0;
    while (!(ch ? Done1 : Done0) && n < 2000) begin
      if (Cnt_En) ens++;
      if (Cnt_En && (Cnt_Slt !== ch)) slt_bad++;
      tick();
      n++;
    end
    chk({tag, "_done_seen"}, 64'(ch ? Done1 : Done0), 64'd1);
    chk({tag, "_slt_stable"}, 64'(slt_bad), 64'd0);
    chk({tag, "_done_en_low"}, 64'(Cnt_En), 64'd0);
  endtask

  initial begin
    int ens;
    int nacks;
    int ack_cyc[4];
    logic ack_ch[4];
    logic seen;

    tick();
    tick();
    chk("reset_outputs", 64'(ob), 64'h00);

    // Len0=3 burst on channel 0
    Reset = 1'b0; Req0 = 1'b1; Len0 = 8'd3;
    tick();
    chk("b0_ack", 64'(ob), 64'h8C);
    Req0 = 1'b0; Len0 = 8'd7;
    tick();
    chk("b0_c2", 64'(ob), 64'h0C);
    tick();
    chk("b0_c3", 64'(ob), 64'h0C);
    tick();
    chk("b0_done", 64'(ob), 64'h28);
    tick();
    chk("b0_idle", 64'(ob), 64'h00);
    chk("b0_out0", out0, 64'd3);

    // Len1=2 burst on channel 1: 8 En cycles
    Req1 = 1'b1; Len1 = 8'd2;
    tick();
    chk("b1_ack", 64'(ob), 64'h4E);
    Req1 = 1'b0;
    wait_done("b1", 1'b1, ens);
    chk("b1_en_cycles", 64'(ens), 64'd8);
    tick();
    chk("b1_out1", out1, 64'd2);
    chk("b1_out0", out0, 64'd3);

    // Both requesters held from reset with Len=1
    Reset = 1'b1;
    tick();
    Reset = 1'b0; Req0 = 1'b1; Req1 = 1'b1; Len0 = 8'd1; Len1 = 8'd1;
    nacks = 0;
    for (int c = 1; c <= 14; c++) begin
      tick();
      if ((Ack0 || Ack1) && nacks < 4) begin
        ack_cyc[nacks] = c;
        ack_ch[nacks]  = Ack1;
        nacks++;
      end
    end
    Req0 = 1'b0; Req1 = 1'b0;
    chk("rr_nacks", 64'(nacks), 64'd4);
    chk("rr_ch0", 64'(ack_ch[0]), 64'd0);
    chk("rr_cyc0", 64'(ack_cyc[0]), 64'd1);
    chk("rr_ch1", 64'(ack_ch[1]), 64'd1);
    chk("rr_cyc1", 64'(ack_cyc[1]), 64'd4);
    chk("rr_ch2", 64'(ack_ch[2]), 64'd0);
    chk("rr_cyc2", 64'(ack_cyc[2]), 64'd10);
    chk("rr_ch3", 64'(ack_ch[3]), 64'd1);
    chk("rr_cyc3", 64'(ack_cyc[3]), 64'd13);
    repeat (6) tick();
    chk("rr_idle", 64'(ob), 64'h00);
    chk("rr_out0", out0, 64'd2);
    chk("rr_out1", out1, 64'd2);

    // Clr beats Req0 in IDLE
    Clr = 1'b1; Req0 = 1'b1; Len0 = 8'd2;
    tick();
    chk("clr_pulse", 64'(ob), 64'h09);
    Clr = 1'b0;
    tick();
    chk("clr_idle", 64'(ob), 64'h00);
    chk("clr_out0", out0, 64'd0);
    tick();
    chk("clr_ack0", 64'(ob), 64'h8C);
    Req0 = 1'b0;
    wait_done("clr_b", 1'b0, ens);
    chk("clr_b_en", 64'(ens), 64'd2);
    tick();

    // Clr during a Len0=5 burst waits for the burst to finish
    Req0 = 1'b1; Len0 = 8'd5;
    tick();
    chk("mid_ack0", 64'(ob), 64'h8C);
    Req0 = 1'b0; Clr = 1'b1;
    wait_done("mid", 1'b0, ens);
    chk("mid_en", 64'(ens), 64'd5);
    tick();
    chk("mid_idle", 64'(ob), 64'h00);
    chk("mid_out0", out0, 64'd7);
    tick();
    chk("mid_clr", 64'(ob), 64'h09);
    Clr = 1'b0;
    tick();
    chk("mid_after", 64'(ob), 64'h00);
    chk("mid_out0_clr", out0, 64'd0);

    // Zero-length burst
    Req0 = 1'b1; Len0 = 8'd0;
    tick();
    chk("zero_ack", 64'(ob), 64'h88);
    Req0 = 1'b0;
    tick();
    chk("zero_done", 64'(ob), 64'h28);
    tick();
    chk("zero_idle", 64'(ob), 64'h00);
    chk("zero_out0", out0, 64'd0);

    // Maximum channel-1 burst
    Req1 = 1'b1; Len1 = 8'd255;
    tick();
    chk("max_ack1", 64'(ob), 64'h4E);
    Req1 = 1'b0;
    wait_done("max", 1'b1, ens);
    chk("max_en", 64'(ens), 64'd1020);
    tick();
    chk("max_out1", out1, 64'd255);
    chk("max_out0", out0, 64'd0);

    // Reset in cycle 2 of a Len0=4 burst
    Req0 = 1'b1; Len0 = 8'd4;
    tick();
    chk("rst_ack0", 64'(ob), 64'h8C);
    Req0 = 1'b0;
    tick();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    chk("rst_outputs", 64'(ob), 64'h00);
    chk("rst_out0", out0, 64'd0);
    seen = 1'b0;
    repeat (5) begin
      tick();
      if (Done0 || Busy || Cnt_En) seen = 1'b1;
    end
    chk("rst_no_done", 64'(seen), 64'd0);

    chk("no_reset_en_overlap", 64'(overlap), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
